// File: rtl/tick_generator_mc_if.sv
// rtl/tick_generator_mc_if.sv - divisor write bus for tick_generator_mc
interface tick_generator_mc_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 18
) ();
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;

    modport master (output wr_en, output wr_ch, output wr_div);
    modport slave  (input  wr_en, input  wr_ch, input  wr_div);
endinterface

// File: rtl/tick_generator_mc.sv
// rtl/tick_generator_mc.sv - multi-channel tick/square generator with shadowed divisors; TICK_SYNC_RESTART_EN adds sync_in
module tick_generator_mc #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int CNT_W       = 18,
    parameter int DEFAULT_DIV = 200000
) (
    input  logic              clock_in,
    input  logic              reset_n,
`ifdef TICK_SYNC_RESTART_EN
    input  logic              sync_in,
`endif
    tick_generator_mc_if.slave wr_bus,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] div_pending
);

    logic sync_restart;

`ifdef TICK_SYNC_RESTART_EN
    assign sync_restart = sync_in;
`else
    assign sync_restart = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] shd_div;
        logic             pending;
        logic             tick_q;
        logic             sq_q;
        logic             en_q;

        logic             wr_hit;
        logic             direct_wr;
        logic [CNT_W-1:0] eff_div;
        logic             terminal;

        // Decode the write and pick the divisor this edge compares against:
        // a write landing on a channel that was idle last cycle takes effect at once.
        always_comb begin
            wr_hit    = 1'b0;
            direct_wr = 1'b0;
            eff_div   = act_div;
            terminal  = 1'b0;
            wr_hit    = wr_bus.wr_en && (wr_bus.wr_ch == CH_W'(i));
            direct_wr = !ch_en[i] || !en_q;
            if (wr_hit && direct_wr) begin
                eff_div = wr_bus.wr_div;
            end
            terminal  = (cnt == eff_div);
        end

        // Per-channel counter, divisor shadowing and output registers.
        always_ff @(posedge clock_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt     <= '0;
                act_div <= CNT_W'(DEFAULT_DIV);
                shd_div <= CNT_W'(DEFAULT_DIV);
                pending <= 1'b0;
                tick_q  <= 1'b0;
                sq_q    <= 1'b0;
                en_q    <= 1'b0;
            end else begin
                en_q <= ch_en[i];
                if (sync_restart || !ch_en[i]) begin
                    // Idle or restarting: park at zero and fold any divisor change in now.
                    cnt     <= '0;
                    tick_q  <= 1'b0;
                    sq_q    <= 1'b0;
                    pending <= 1'b0;
                    if (wr_hit) begin
                        act_div <= wr_bus.wr_div;
                        shd_div <= wr_bus.wr_div;
                    end else if (pending) begin
                        act_div <= shd_div;
                    end
                end else begin
                    if (wr_hit && direct_wr) begin
                        act_div <= wr_bus.wr_div;
                        shd_div <= wr_bus.wr_div;
                    end
                    if (terminal) begin
                        cnt    <= '0;
                        tick_q <= 1'b1;
                        sq_q   <= ~sq_q;
                        // Shadow only swaps in at cnt=0, so the counter can never overshoot.
                        if (pending) begin
                            act_div <= shd_div;
                            pending <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        tick_q <= 1'b0;
                    end
                    // A write to a running channel waits for the next terminal; later writes overwrite it.
                    if (wr_hit && !direct_wr) begin
                        shd_div <= wr_bus.wr_div;
                        pending <= 1'b1;
                    end
                end
            end
        end

        assign tick_out[i]    = tick_q;
        assign sq_out[i]      = sq_q;
        assign div_pending[i] = pending;
    end

endmodule

// File: tb/tb_tick_generator_mc.sv
// tb/tb_tick_generator_mc.sv - self-checking bench for tick_generator_mc against a countdown reference model
module tb_tick_generator_mc;

    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;

    logic              clock_in = 1'b0;
    logic              reset_n  = 1'b0;
    logic [NUM_CH-1:0] ch_en    = '0;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] sq_out;
    logic [NUM_CH-1:0] div_pending;
`ifdef TICK_SYNC_RESTART_EN
    logic              sync_in  = 1'b0;
`endif

    tick_generator_mc_if #(.CH_W(CH_W), .CNT_W(CNT_W)) wr_bus ();

    tick_generator_mc #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
`ifdef TICK_SYNC_RESTART_EN
        .sync_in     (sync_in),
`endif
        .wr_bus      (wr_bus),
        .ch_en       (ch_en),
        .tick_out    (tick_out),
        .sq_out      (sq_out),
        .div_pending (div_pending)
    );

    always #5 clock_in = ~clock_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel counts DOWN the edges remaining before its terminal edge,
    // with an optional queued next divisor.
    int                m_rem  [NUM_CH];
    int                m_div  [NUM_CH];
    int                m_next [NUM_CH];
    logic [NUM_CH-1:0] m_nv;
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_sq;
    logic [NUM_CH-1:0] m_prev_en;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_rem[i]  = DEF_DIV;
            m_div[i]  = DEF_DIV;
            m_next[i] = 0;
        end
        m_nv = '0; m_tick = '0; m_sq = '0; m_prev_en = '0;
    endtask

    task automatic model_step();
        logic sync_v;
        sync_v = 1'b0;
`ifdef TICK_SYNC_RESTART_EN
        sync_v = sync_in;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            logic hit, en, fresh;
            int   wd;
            wd    = int'(wr_bus.wr_div);
            hit   = wr_bus.wr_en && (int'(wr_bus.wr_ch) == i);
            en    = ch_en[i];
            fresh = 1'b0;
            if (sync_v || !en) begin
                if (hit) m_div[i] = wd;
                else if (m_nv[i]) m_div[i] = m_next[i];
                m_nv[i] = 1'b0; m_rem[i] = m_div[i]; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else begin
                fresh = hit && !m_prev_en[i];
                if (fresh) begin
                    m_div[i] = wd;
                    m_rem[i] = wd;
                end
                if (m_rem[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_sq[i]   = !m_sq[i];
                    if (m_nv[i]) begin
                        m_div[i] = m_next[i];
                        m_nv[i]  = 1'b0;
                    end
                    m_rem[i] = m_div[i];
                end else begin
                    m_rem[i]  = m_rem[i] - 1;
                    m_tick[i] = 1'b0;
                end
                if (hit && !fresh) begin
                    m_next[i] = wd;
                    m_nv[i]   = 1'b1;
                end
            end
            m_prev_en[i] = en;
        end
    endtask

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clock_in) begin
        check_val("tick_out", 32'(tick_out), 32'(m_tick));
        check_val("sq_out", 32'(sq_out), 32'(m_sq));
        check_val("div_pending", 32'(div_pending), 32'(m_nv));
    end

    task automatic drive_wr(input int ch, input int div);
        wr_bus.wr_en  = 1'b1;
        wr_bus.wr_ch  = CH_W'(ch);
        wr_bus.wr_div = CNT_W'(div);
        @(negedge clock_in);
        wr_bus.wr_en  = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int gap);
        gap = 0;
        do begin
            @(negedge clock_in);
            gap++;
        end while (!tick_out[ch] && gap < 300);
        check_val("tick_timeout", 32'(tick_out[ch]), 32'd1);
    endtask

    int gap;

    initial begin
        wr_bus.wr_en = 1'b0; wr_bus.wr_ch = '0; wr_bus.wr_div = '0;
        repeat (3) @(negedge clock_in);
        check_val("rst_tick", 32'(tick_out), 32'd0);
        check_val("rst_sq", 32'(sq_out), 32'd0);
        check_val("rst_pend", 32'(div_pending), 32'd0);
        reset_n = 1'b1;
        @(negedge clock_in);

        // Channel 0 alone at the default divisor: period 5, sq period 10.
        ch_en = 3'b001;
        for (int k = 0; k < 3; k++) begin
            wait_tick(0, gap);
            check_val("def_gap", 32'(gap), 32'd5);
        end
        check_val("def_sq", 32'(sq_out), 32'b001);
        check_val("def_others", 32'(tick_out), 32'b001);

        // Write 2 at cnt=1: current period still 5, then 3.
        @(negedge clock_in);
        drive_wr(0, 2);
        check_val("mid_pend", 32'(div_pending[0]), 32'd1);
        wait_tick(0, gap);
        check_val("mid_gap_old", 32'(gap), 32'd3);
        check_val("mid_pend_clr", 32'(div_pending[0]), 32'd0);
        wait_tick(0, gap);
        check_val("mid_gap_new", 32'(gap), 32'd3);
        wait_tick(0, gap);
        check_val("mid_gap_new2", 32'(gap), 32'd3);

        // Write 7 on a terminal edge, then 3 before the next terminal: only 3 is used.
        @(negedge clock_in);
        @(negedge clock_in);
        drive_wr(0, 7);
        check_val("term_tick", 32'(tick_out[0]), 32'd1);
        check_val("term_pend", 32'(div_pending[0]), 32'd1);
        @(negedge clock_in);
        drive_wr(0, 3);
        wait_tick(0, gap);
        check_val("term_gap_old", 32'(gap), 32'd1);
        check_val("term_pend_clr", 32'(div_pending[0]), 32'd0);
        for (int k = 0; k < 2; k++) begin
            wait_tick(0, gap);
            check_val("term_gap_last", 32'(gap), 32'd4);
        end

        // Divisor 0 on a disabled channel, then enable: tick every cycle.
        drive_wr(1, 0);
        ch_en[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock_in);
            check_val("div0_tick", 32'(tick_out[1]), 32'd1);
            check_val("div0_sq", 32'(sq_out[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_val("div0_pend", 32'(div_pending[1]), 32'd0);
        end

        // Enable rise together with a write: first period already uses the new divisor.
        ch_en[2] = 1'b1;
        drive_wr(2, 1);
        wait_tick(2, gap);
        check_val("rise_gap_first", 32'(gap), 32'd1);
        check_val("rise_pend", 32'(div_pending[2]), 32'd0);
        wait_tick(2, gap);
        check_val("rise_gap", 32'(gap), 32'd2);

        // Asynchronous reset mid-period with a write pending.
        ch_en = 3'b001;
        @(negedge clock_in);
        drive_wr(0, 9);
        check_val("ar_pend_set", 32'(div_pending[0]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("ar_tick", 32'(tick_out), 32'd0);
        check_val("ar_sq", 32'(sq_out), 32'd0);
        check_val("ar_pend", 32'(div_pending), 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;
        wait_tick(0, gap);
        check_val("ar_gap", 32'(gap), 32'd5);
        drive_wr(3, 1);
        check_val("badch_pend", 32'(div_pending), 32'd0);
        wait_tick(0, gap);
        check_val("badch_gap", 32'(gap), 32'd4);

`ifdef TICK_SYNC_RESTART_EN
        // Phase alignment: divisors 2 and 4 restarted together.
        ch_en = 3'b000;
        @(negedge clock_in);
        drive_wr(0, 2);
        drive_wr(1, 4);
        ch_en = 3'b011;
        repeat ($urandom_range(1, 9)) @(negedge clock_in);
        sync_in = 1'b1;
        @(negedge clock_in);
        sync_in = 1'b0;
        check_val("sync_tick0", 32'(tick_out), 32'd0);
        check_val("sync_sq0", 32'(sq_out), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock_in);
            check_val("sync_t0", 32'(tick_out[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
            check_val("sync_t1", 32'(tick_out[1]), (k % 5 == 0) ? 32'd1 : 32'd0);
        end
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom_range(0, 7));
            wr_bus.wr_en  = ($urandom_range(0, 2) == 0);
            wr_bus.wr_ch  = CH_W'($urandom_range(0, 3));
            wr_bus.wr_div = CNT_W'($urandom_range(0, 10));
`ifdef TICK_SYNC_RESTART_EN
            sync_in = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            @(negedge clock_in);
        end
        wr_bus.wr_en = 1'b0;
        @(negedge clock_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_generator_mc.md
Name: tick_generator_mc

Overview:
- Multi-channel programmable clock-enable generator; parametrised successor of the single fixed-ratio divider.
- Each channel has its own counter and a run-time writable divisor with glitch-free shadow update.
- Each channel drives a one-cycle tick strobe and a 50%-duty square output.
- Sits beside the pipeline top level and supplies slow enables (display refresh, single-step, debounce) from the board clock.

Parameters:
- NUM_CH, 4, number of independent channels (1..2**CH_W)
- CH_W, 2, width of the channel-select field
- CNT_W, 18, counter and divisor width
- DEFAULT_DIV, 200000, divisor loaded into every channel at reset; must fit in CNT_W

Ports:
- clock_in  input  1  system clock; all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  divisor write strobe, sampled on posedge
- wr_ch  input  CH_W  target channel; values >= NUM_CH ignore the write
- wr_div  input  CNT_W  new divisor value
- ch_en  input  NUM_CH  per-channel run enable
- tick_out  output  NUM_CH  one-cycle strobe per channel period
- sq_out  output  NUM_CH  square wave, toggles at each terminal count
- div_pending  output  NUM_CH  shadow divisor written but not yet active

Behaviour:
- Per-channel state: cnt[CNT_W], act_div[CNT_W], shd_div[CNT_W], pending flag, tick register, sq register.
- Reset (reset_n=0, asynchronous):
  - cnt=0; act_div=shd_div=DEFAULT_DIV.
  - tick_out=0, sq_out=0, div_pending=0.
  - Reset mid-count discards all progress and any pending write.
- All outputs are registered; no combinational path from inputs to outputs.
- Channel disabled (ch_en[i]=0):
  - cnt forced to 0; tick_out[i]=0 and sq_out[i]=0 at the next edge.
  - A pending shadow is copied into act_div; pending cleared.
- Channel enabled, edge where cnt==act_div (terminal count):
  - cnt<=0, tick_out[i]<=1, sq_out[i]<=~sq_out[i].
  - If pending: act_div<=shd_div and pending<=0.
- Channel enabled, any other edge: cnt<=cnt+1, tick_out[i]<=0.
- Timing:
  - Period = act_div+1 cycles; sq_out period = 2*(act_div+1).
  - act_div=0: tick_out held high every cycle; sq_out toggles every cycle.
  - First tick is high in the cycle after the (act_div+1)-th edge with ch_en high, counted from cnt=0.
- Write handling (wr_en=1, wr_ch<NUM_CH):
  - Enabled channel: shd_div<=wr_div, pending<=1; the running period completes with the old divisor (no truncated or stretched period).
  - Disabled channel: act_div<=wr_div and shd_div<=wr_div directly; pending stays 0.
- Boundary cases:
  - Write in the same cycle as a terminal count: that terminal uses the old act_div; the new value becomes pending and applies at the next terminal.
  - Write while already pending: shd_div is overwritten; the last write wins.
  - Write and enable rise on a previously disabled channel in the same cycle: treated as a disabled-channel write, so the first period already uses wr_div.
  - Counter never exceeds act_div, because a new divisor is applied only at cnt=0. No wrap-around beyond 2**CNT_W-1 is possible.
  - Channels are fully independent; a write to channel i never disturbs channel j.

Optional Feature:
- Macro: TICK_SYNC_RESTART_EN.
- When defined:
  - Adds input sync_in (1 bit).
  - On an edge with sync_in=1, every channel sets cnt<=0 and sq_out<=0, and tick_out is 0 that cycle.
  - Any pending shadow is applied immediately and pending cleared.
  - sync_in has priority over terminal count and over the enable logic; writes in the same cycle land as if the channel were disabled.
  - Gives phase-aligned outputs across channels.
- When undefined: the port is absent and channels run free-phase relative to each other.

Test Plan:
- Reset, then ch_en=4'b0001 with DEFAULT_DIV overridden to 4 -> tick_out[0] pulses exactly once every 5 cycles; sq_out[0] period 10; all other outputs stay 0.
- Channel 0 running, div=4; write wr_ch=0, wr_div=2 at cnt=1 -> div_pending[0]=1 until the next terminal; that period still lasts 5 cycles; following periods last 3 cycles; pending drops to 0.
- Write div=0 to disabled channel 1, then enable -> tick_out[1] high every cycle; sq_out[1] toggles every cycle; div_pending[1] never set.
- Write in the same cycle as terminal count, then a second write before the next terminal (values 7, then 3) -> only 3 takes effect, one period later; 7 is never used.
- Assert reset_n=0 asynchronously mid-period with a pending write -> all outputs 0 immediately; after release, period = DEFAULT_DIV+1; write with wr_ch=3 and NUM_CH=3 -> no state change.
- TICK_SYNC_RESTART_EN defined: channels at div 2 and 4 with arbitrary phase; pulse sync_in -> both tick in the same cycle 3 and 5 cycles later respectively, and coincide every 15 cycles.
